// File: rtl/pp_row_seq.sv
// Sequential partial-product row generator: latches one operand pair and streams
// ROWS weighted rows (AND-array or radix-4 Booth) over a valid/ready output.
module pp_row_seq #(
    parameter int WIDTH = 16,
    parameter int BOOTH = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           out_row,
    output logic [((((BOOTH != 0) ? WIDTH/2 : WIDTH) > 1) ?
                   $clog2((BOOTH != 0) ? WIDTH/2 : WIDTH) : 1)-1:0] out_idx,
    output logic                         out_last
);

    localparam int ROWS  = (BOOTH != 0) ? WIDTH / 2 : WIDTH;
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROW_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               valid_q, valid_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_next;

    // Booth digits are built from the B triple {b[2i+1], b[2i], b[2i-1]} with b[-1]=0,
    // so B is padded with a zero LSB; multiples are formed at full row width to avoid overflow.
    function automatic logic [ROW_W-1:0] calc_row(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [IDX_W-1:0] idx
    );
        logic [ROW_W-1:0] a_ext;
        logic [ROW_W-1:0] mult;
        logic [WIDTH:0]   b_ext;
        logic [2:0]       digit;
        logic [ROW_W-1:0] row;
        a_ext = '0;
        mult  = '0;
        b_ext = '0;
        digit = '0;
        row   = '0;
        if (BOOTH == 0) begin
            a_ext = {{WIDTH{1'b0}}, a};
            row   = b[idx] ? (a_ext << idx) : '0;
        end else begin
            a_ext = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext = {b, 1'b0};
            digit = 3'(b_ext >> {idx, 1'b0});
            case (digit)
                3'b001, 3'b010: mult = a_ext;
                3'b011:         mult = a_ext << 1;
                3'b100:         mult = -(a_ext << 1);
                3'b101, 3'b110: mult = -a_ext;
                default:        mult = '0;
            endcase
            row = mult << {idx, 1'b0};
        end
        return row;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            row_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = valid_q;
        row_d    = row_q;
        idx_d    = idx_q;
        last_d   = last_q;
        idx_next = idx_q + IDX_W'(1);
        in_ready = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    row_d   = calc_row(in_a, in_b, '0);
                    idx_d   = '0;
                    last_d  = (LAST_IDX == '0);
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // Output registers only move on a handshake, which gives stable backpressure.
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        row_d   = '0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idx_next;
                        row_d  = calc_row(a_q, b_q, idx_next);
                        last_d = (idx_next == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = valid_q;
    assign out_row   = row_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule
